// File: rtl/sum4b_seq_ctrl.sv
// sum4b_seq_ctrl
//   Runs a WIDTH-bit add or subtract through one shared external 4-bit
//   ripple adder (sum4b). Each operation takes one nibble per cycle, LSB
//   first. The carry between nibbles is held in a register here. The
//   result stays on Sum/Cout/Ovf until the next accepted start.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start             request; only sampled while idle
//   sub               0: A+B+Ci   1: A-B (A + ~B + 1, Ci ignored)
//   A, B, Ci          operands and add carry-in, sampled with start
//   busy              high while running and during the done cycle
//   done              one-cycle pulse, result valid
//   Sum, Cout, Ovf    result, final carry (sub: 1 = no borrow), signed overflow
//   add_A/B/Ci        to the external sum4b (all zero when not running)
//   add_Sum/Cout      from the external sum4b
module sum4b_seq_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf,
  output logic [3:0]       add_A,
  output logic [3:0]       add_B,
  output logic             add_Ci,
  input  logic [3:0]       add_Sum,
  input  logic             add_Cout
);

  localparam int unsigned NIB  = WIDTH / 4;
  localparam int unsigned IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NIB - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  opa_q, opa_d;
  logic [WIDTH-1:0]  opb_q, opb_d;
  logic              carry_q, carry_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;

  // Nibble base bit index (4*idx) built by concatenation to keep widths exact.
  logic [IDXW+1:0]   base;
  assign base = {idx_q, 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    busy    = 1'b0;
    done    = 1'b0;
    add_A   = '0;
    add_B   = '0;
    add_Ci  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          // Subtraction is A + ~B + 1: invert B once at capture, seed carry with 1.
          opa_d   = A;
          opb_d   = sub ? ~B : B;
          carry_d = sub ? 1'b1 : Ci;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        busy   = 1'b1;
        add_A  = opa_q[base +: 4];
        add_B  = opb_q[base +: 4];
        add_Ci = carry_q;
        sum_d[base +: 4] = add_Sum;
        carry_d = add_Cout;
        idx_d   = idx_q + IDXW'(1);
        if (idx_q == LAST) begin
          cout_d  = add_Cout;
          // Overflow: like-signed operands (B already inverted for sub) give an unlike-signed result.
          ovf_d   = (opa_q[WIDTH-1] == opb_q[WIDTH-1]) && (add_Sum[3] != opa_q[WIDTH-1]);
          idx_d   = '0;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign Sum  = sum_q;
  assign Cout = cout_q;
  assign Ovf  = ovf_q;

endmodule

// File: tb/tb_sum4b_seq_ctrl.sv
module tb_sum4b_seq_ctrl;

  localparam int NIB = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, sub, Ci;
  logic [15:0] A, B;
  logic        busy, done, Cout, Ovf;
  logic [15:0] Sum;
  logic [3:0]  add_A, add_B, add_Sum;
  logic        add_Ci, add_Cout;
  logic [4:0]  adder_full;

  sum4b_seq_ctrl #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .A(A), .B(B), .Ci(Ci),
    .busy(busy), .done(done), .Sum(Sum), .Cout(Cout), .Ovf(Ovf),
    .add_A(add_A), .add_B(add_B), .add_Ci(add_Ci),
    .add_Sum(add_Sum), .add_Cout(add_Cout)
  );

  // External 4-bit ripple adder stand-in.
  assign adder_full = {1'b0, add_A} + {1'b0, add_B} + {4'b0, add_Ci};
  assign add_Sum    = adder_full[3:0];
  assign add_Cout   = adder_full[4];

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Continuous checks: done never two cycles wide, adder idle outside RUN.
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    n_vec++;
    if (done === 1'b1 && prev_done === 1'b1) begin
      n_bad++;
      $display("FAIL done_width: done high two cycles in a row (t=%0t)", $time);
    end
    if (!(busy === 1'b1 && done === 1'b0)) begin
      n_vec++;
      if ({add_A, add_B, add_Ci} !== 9'd0) begin
        n_bad++;
        $display("FAIL add_idle: add_A=%h add_B=%h add_Ci=%b expected 0 (t=%0t)",
                 add_A, add_B, add_Ci, $time);
      end
    end
    prev_done = done;
  end

  typedef struct {
    logic        sub;
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs[9];

  // Applies one operation; checks every RUN cycle's adder drive against a
  // nibble-carry model, then the done cycle and the hold cycle after it.
  // poke: raise start with junk operands two cycles into RUN (must be ignored).
  task automatic run_op(input vec_t v, input bit poke, input string tag);
    logic [15:0] opb;
    logic        c;
    logic [3:0]  an, bn;
    logic [4:0]  s;
    opb = v.sub ? ~v.b : v.b;
    c   = v.sub ? 1'b1 : v.ci;
    @(negedge clk);
    start = 1'b1; sub = v.sub; A = v.a; B = v.b; Ci = v.ci;
    @(negedge clk);
    start = 1'b0; A = 16'($urandom); B = 16'($urandom);
    sub = 1'($urandom); Ci = 1'($urandom);
    for (int n = 0; n < NIB; n++) begin
      if (n > 0) @(negedge clk);
      an = v.a[4*n +: 4];
      bn = opb[4*n +: 4];
      chk({tag, " busy_run"}, 32'(busy), 32'd1);
      chk({tag, " done_run"}, 32'(done), 32'd0);
      chk({tag, " add_A"},  32'(add_A),  32'(an));
      chk({tag, " add_B"},  32'(add_B),  32'(bn));
      chk({tag, " add_Ci"}, 32'(add_Ci), 32'(c));
      s = {1'b0, an} + {1'b0, bn} + {4'b0, c};
      c = s[4];
      if (poke && n == 1) begin
        start = 1'b1; A = 16'hAAAA; B = 16'h5555; sub = 1'b1; Ci = 1'b0;
      end
      if (poke && n == 2) start = 1'b0;
    end
    @(negedge clk);
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " busy_done"}, 32'(busy), 32'd1);
    chk({tag, " Sum"},  32'(Sum),  32'(v.sum));
    chk({tag, " Cout"}, 32'(Cout), 32'(v.cout));
    chk({tag, " Ovf"},  32'(Ovf),  32'(v.ovf));
    @(negedge clk);
    chk({tag, " done_after"}, 32'(done), 32'd0);
    chk({tag, " busy_after"}, 32'(busy), 32'd0);
    chk({tag, " Sum_hold"},   32'(Sum),  32'(v.sum));
  endtask

  initial begin
    //            sub   A         B         Ci    Sum       Cout  Ovf
    vecs[0] = '{1'b0, 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{1'b0, 16'h00FF, 16'h0F00, 1'b1, 16'h1000, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[8] = '{1'b1, 16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b1, 1'b0};

    rst_n = 1'b0; start = 1'b0; sub = 1'b0; Ci = 1'b0; A = '0; B = '0;
    #12;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst Sum",  32'(Sum),  32'd0);
    chk("rst Cout", 32'(Cout), 32'd0);
    chk("rst Ovf",  32'(Ovf),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) run_op(vecs[i], 1'b0, $sformatf("v%0d", i));

    // Start during busy is ignored; the original result and one done remain.
    run_op(vecs[0], 1'b1, "busy_poke");

    // Reset mid-RUN aborts with no done pulse; next op runs normally.
    @(negedge clk);
    start = 1'b1; sub = 1'b0; A = 16'h1234; B = 16'h0FFF; Ci = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort busy",  32'(busy), 32'd0);
    chk("abort done",  32'(done), 32'd0);
    chk("abort Sum",   32'(Sum),  32'd0);
    chk("abort add",   32'({add_A, add_B, add_Ci}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < NIB + 3; k++) begin
      @(negedge clk);
      chk("abort no_done", 32'(done), 32'd0);
      chk("abort no_busy", 32'(busy), 32'd0);
    end
    run_op(vecs[3], 1'b0, "post_rst");

    // start held high: accepted again every NIB+2 cycles.
    @(negedge clk);
    start = 1'b1; sub = 1'b0; A = 16'h1234; B = 16'h0FFF; Ci = 1'b0;
    for (int k = 0; k < 2 * (NIB + 2); k++) begin
      chk($sformatf("hold busy k%0d", k), 32'(busy), 32'((k % (NIB + 2)) != 0));
      chk($sformatf("hold done k%0d", k), 32'(done), 32'((k % (NIB + 2)) == NIB + 1));
      if ((k % (NIB + 2)) == NIB + 1) chk("hold Sum", 32'(Sum), 32'h2233);
      @(negedge clk);
    end
    start = 1'b0;
    repeat (NIB + 3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
